imem_boot_loader: RTL and testbench

//  Boot sequencer for the 16-bit RISC core. Holds the core in reset after power-up.

---
 rtl/imem_boot_loader_pkg.sv | 23 ++
 rtl/imem_boot_loader_cksum.sv | 33 +++
 rtl/imem_boot_loader.sv | 152 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared constants and state encoding for the boot loader
package imem_boot_loader_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;
    localparam int WORDS  = 64;
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [7:0] HDR     = 8'hA5;
    localparam logic [7:0] WORDS_B = 8'(WORDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_WRITE,
        ST_CHECK,
        ST_RUN,
        ST_ERROR
    } boot_state_e;

endpackage

// File: rtl/imem_boot_loader_cksum.sv
// rtl/imem_boot_loader_cksum.sv - XOR accumulator over frame data bytes
module imem_boot_loader_cksum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] sum
);

    logic [7:0] sum_q;
    logic [7:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = 8'h00;
        end else if (en) begin
            sum_d = sum_q ^ data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads a framed byte-stream image into instruction memory,
// then releases the core from reset
module imem_boot_loader
    import imem_boot_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              boot_bypass,
    output logic              im_wr_en,
    output logic [ADDR_W-1:0] im_wr_addr,
    output logic [DATA_W-1:0] im_wr_data,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    boot_state_e       state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [7:0]        hi_q, hi_d;
    logic              wr_en_q, wr_en_d;
    logic              rx_ready_q, rx_ready_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ck_clr;
    logic              ck_en;
    logic [7:0]        ck_sum;
    logic              accept;
    logic [CNT_W-1:0]  written;

    assign accept  = rx_valid & rx_ready_q;
    // Count is one bit wider than the address so a full 64-word image terminates on wrap.
    assign written = {1'b0, addr_q} + CNT_W'(1);

    imem_boot_loader_cksum u_cksum (
        .clk  (clk),
        .rst  (rst),
        .clr  (ck_clr),
        .en   (ck_en),
        .data (rx_data),
        .sum  (ck_sum)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        addr_d  = addr_q;
        data_d  = data_q;
        hi_d    = hi_q;
        wr_en_d = 1'b0;
        ck_clr  = 1'b0;
        ck_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept && rx_data == HDR) begin
                    state_d = ST_COUNT;
                end else if (boot_bypass) begin
                    state_d = ST_RUN;
                end
            end
            ST_COUNT: begin
                if (accept) begin
                    if (rx_data == 8'h00 || rx_data > WORDS_B) begin
                        state_d = ST_ERROR;
                    end else begin
                        n_d     = rx_data[CNT_W-1:0];
                        addr_d  = '0;
                        ck_clr  = 1'b1;
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (accept) begin
                    hi_d    = rx_data;
                    ck_en   = 1'b1;
                    state_d = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (accept) begin
                    data_d  = {hi_q, rx_data};
                    wr_en_d = 1'b1;
                    ck_en   = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = (written == n_q) ? ST_CHECK : ST_DATA_HI;
            end
            ST_CHECK: begin
                if (accept) begin
                    state_d = (rx_data == ck_sum) ? ST_RUN : ST_ERROR;
                end
            end
            ST_RUN, ST_ERROR: begin
                if (accept && rx_data == HDR) begin
                    state_d = ST_COUNT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Status outputs are registered from the next state so they settle one cycle after the deciding byte.
        rx_ready_d = (state_d != ST_WRITE);
        cpu_rst_d  = (state_d != ST_RUN);
        done_d     = (state_d == ST_RUN);
        err_d      = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            hi_q       <= 8'h00;
            wr_en_q    <= 1'b0;
            rx_ready_q <= 1'b1;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            hi_q       <= hi_d;
            wr_en_q    <= wr_en_d;
            rx_ready_q <= rx_ready_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign im_wr_en   = wr_en_q;
    assign im_wr_addr = addr_q;
    assign im_wr_data = data_q;
    assign cpu_rst    = cpu_rst_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - scoreboard bench for the instruction memory boot loader
module tb_imem_boot_loader;

    logic        clk;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        boot_bypass;
    logic        im_wr_en;
    logic [5:0]  im_wr_addr;
    logic [15:0] im_wr_data;
    logic        cpu_rst;
    logic        done;
    logic        err;

    typedef struct {
        logic [5:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] img[64];
    int          vectors;
    int          miscompares;

    imem_boot_loader dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .boot_bypass (boot_bypass),
        .im_wr_en    (im_wr_en),
        .im_wr_addr  (im_wr_addr),
        .im_wr_data  (im_wr_data),
        .cpu_rst     (cpu_rst),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst) begin
            chk_eq("rdy_vs_wr", {31'd0, rx_ready}, {31'd0, ~im_wr_en});
            if (im_wr_en) begin
                if (exp_q.size() == 0) begin
                    chk_eq("unexpected_wr", 32'd1, 32'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk_eq("wr_addr", {26'd0, im_wr_addr}, {26'd0, e.addr});
                    chk_eq("wr_data", {16'd0, im_wr_data}, {16'd0, e.data});
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk_eq("rx_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
    endtask

    task automatic end_frame();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit bad);
        logic [7:0] c;
        c = 8'h00;
        send_byte(8'hA5);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{addr: 6'(i), data: img[i]});
            send_byte(img[i][15:8]);
            send_byte(img[i][7:0]);
            c = c ^ img[i][15:8] ^ img[i][7:0];
        end
        send_byte(bad ? (c ^ 8'h01) : c);
        end_frame();
    endtask

    task automatic chk_status(input string tag, input logic r, input logic d, input logic e);
        chk_eq({tag, "_cpu_rst"}, {31'd0, cpu_rst}, {31'd0, r});
        chk_eq({tag, "_done"},    {31'd0, done},    {31'd0, d});
        chk_eq({tag, "_err"},     {31'd0, err},     {31'd0, e});
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        boot_bypass = 1'b0;
        #1;
        chk_status("reset", 1'b1, 1'b0, 1'b0);
        chk_eq("reset_rdy",  {31'd0, rx_ready}, 32'd1);
        chk_eq("reset_wren", {31'd0, im_wr_en}, 32'd0);
        chk_eq("reset_addr", {26'd0, im_wr_addr}, 32'd0);
        chk_eq("reset_data", {16'd0, im_wr_data}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Two-word image with good checksum (0x40)
        img[0] = 16'h1234;
        img[1] = 16'hABCD;
        send_frame(2, 1'b0);
        chk_status("t1", 1'b0, 1'b1, 1'b0);

        // Bad checksum, then recovery
        send_frame(2, 1'b1);
        chk_status("t2_bad", 1'b1, 1'b0, 1'b1);
        send_frame(2, 1'b0);
        chk_status("t2_good", 1'b0, 1'b1, 1'b0);

        // Count out of range
        send_byte(8'hA5);
        send_byte(8'h00);
        end_frame();
        chk_status("t3_n0", 1'b1, 1'b0, 1'b1);
        send_byte(8'hA5);
        send_byte(8'h41);
        end_frame();
        chk_status("t3_n65", 1'b1, 1'b0, 1'b1);

        // Full 64-word image with valid held high throughout
        for (int i = 0; i < 64; i++) img[i] = 16'($urandom);
        send_frame(64, 1'b0);
        chk_status("t4", 1'b0, 1'b1, 1'b0);
        chk_eq("t4_addr_wrap", {26'd0, im_wr_addr}, 32'd0);
        chk_eq("t4_sb_empty", exp_q.size(), 32'd0);

        // Reset mid-frame after three words
        send_byte(8'hA5);
        send_byte(8'h08);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{addr: 6'(i), data: img[i]});
            send_byte(img[i][15:8]);
            send_byte(img[i][7:0]);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_status("t5_rst", 1'b1, 1'b0, 1'b0);
        chk_eq("t5_rdy",  {31'd0, rx_ready}, 32'd1);
        chk_eq("t5_addr", {26'd0, im_wr_addr}, 32'd0);
        chk_eq("t5_sb_empty", exp_q.size(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        img[0] = 16'h0F0F;
        img[1] = 16'hBEEF;
        img[2] = 16'h0001;
        send_frame(3, 1'b0);
        chk_status("t5_reload", 1'b0, 1'b1, 1'b0);

        // Bypass from IDLE, then reload request from RUN
        pulse_reset();
        boot_bypass = 1'b1;
        @(negedge clk);
        boot_bypass = 1'b0;
        chk_status("t6_bypass", 1'b0, 1'b1, 1'b0);
        send_byte(8'hA5);
        end_frame();
        chk_status("t6_reload", 1'b1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk_eq("final_sb_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
